systolic_act_feeder: RTL and testbench
======================================

SYSTOLIC_ACT_FEEDER -- requirements
Module: systolic_act_feeder

Interface
REQ-001 Parameter WORD_WIDTH, default 8: activation word width in bits.
REQ-002 Parameter ARRAY_SIZE, default 4: number of array rows fed; legal range 2..16.
REQ-003 clk  input  1: single clock; all state updates on posedge clk.
REQ-004 reset_n  input  1: asynchronous, active-low reset.
REQ-005 start  input  1: one-cycle request to begin a weight-load plus compute session.
REQ-006 act_valid  input  1: act_in holds a valid activation vector.
REQ-007 act_last  input  1: qualified by act_valid; marks the final vector of the session.
REQ-008 act_in  input  ARRAY_SIZE*WORD_WIDTH: row r activation in bits [r*WORD_WIDTH +: WORD_WIDTH].
REQ-009 act_ready  output  1: feeder accepts act_in this cycle.
REQ-010 a_out  output  ARRAY_SIZE*WORD_WIDTH: skewed activations to left-column PE a_in ports, same row packing.
REQ-011 control_out  output  2*ARRAY_SIZE: per-row PE control, row r in bits [2r +: 2].
REQ-012 busy  output  1: high whenever the state is not IDLE.
REQ-013 done  output  1: one-cycle pulse when DRAIN completes.

Function
REQ-014 Control encodings: IDLE 2'b00, WEIGHT_INPUT 2'b01, MULTIPLY 2'b10; 2'b11 is never driven.
REQ-015 FSM states: IDLE, LOAD, COMPUTE, DRAIN; all outputs registered.
REQ-016 IDLE: control_out all rows 00, a_out 0, act_ready 0; start moves the FSM to LOAD on the next edge.
REQ-017 start in any state other than IDLE is ignored.
REQ-018 LOAD: lasts exactly ARRAY_SIZE cycles; all rows drive 01; a_out 0; act_ready 0; then the FSM goes to COMPUTE.
REQ-019 LOAD to COMPUTE goes directly from 01 to 10 with no intervening 00 or 11, so PE weights are never cleared.
REQ-020 COMPUTE: all rows drive 10; act_ready 1; a handshake is act_valid and act_ready.
REQ-021 Skew: a vector accepted at cycle t appears on row r of a_out at cycle t+1+r; the row-0 latency is 1.
REQ-022 A COMPUTE cycle without a handshake injects a zero bubble into every row delay line; control stays 10.
REQ-023 A handshake with act_last moves the FSM to DRAIN on the next edge; act_ready drops to 0 in that same edge.
REQ-024 DRAIN: all rows remain 10 and zeros are injected at row entries.
REQ-025 DRAIN lasts exactly 2*ARRAY_SIZE-1 cycles, so every skewed word and partial sum exits the array.
REQ-026 When the DRAIN counter reaches terminal count, done pulses for 1 cycle and the FSM enters IDLE, driving control 00 from the next cycle.
REQ-027 act_valid outside COMPUTE is ignored; no data is captured.
REQ-028 Cycle counters are sized ceil(log2(2*ARRAY_SIZE)) bits and do not wrap within a state.
REQ-029 Data are passed unmodified; there is no arithmetic on activations.

Reset
REQ-030 While reset_n is low: FSM in IDLE, all delay-line registers 0, a_out 0, control_out 0, act_ready 0, busy 0, done 0, counters 0.
REQ-031 Reset asserted mid-session aborts immediately: no done pulse, and in-flight data are discarded.
REQ-032 The first start after reset release behaves as a fresh session.

Structure
REQ-033 The control encodings 00/01/10 are defined in the shared package, alongside the PE definitions.
REQ-034 The row delay is implemented by sub-module skew_delay_line, parameters WORD_WIDTH and DEPTH; row r is instantiated with DEPTH r+1, with a synchronous clear input.
REQ-035 FSM and counters are in the top module; there are no latches and no combinational output paths from act_in.

Verification
REQ-036 ARRAY_SIZE=4, start pulse -> busy next cycle; control_out=8'h55 for exactly 4 cycles, then 8'hAA.
REQ-037 Vectors {4,3,2,1} then {8,7,6,5} with last on the second, back-to-back -> row0 outputs 1,5 at t+1,t+2; row3 outputs 4,8 at t+4,t+5.
REQ-038 act_valid low for 2 cycles between vectors -> 2 zero bubbles on each row, same relative skew, control stays 10.
REQ-039 After the last vector -> DRAIN 7 cycles with a_out zero once flushed; done pulses once; control 00 the following cycle; busy low.
REQ-040 reset_n pulsed low during COMPUTE -> all outputs 0 at once; no done; a new start yields a normal 4-cycle LOAD.
REQ-041 start during COMPUTE, and act_valid during LOAD -> no state change and no data accepted.

Source files
------------

// File: rtl/systolic_act_feeder_pkg.sv
// Shared definitions for the systolic activation feeder: PE control encodings,
// feeder FSM states and the state-to-control mapping.
package systolic_act_feeder_pkg;

    // PE control word; 2'b11 is reserved and never driven
    typedef enum logic [1:0] {
        PE_IDLE         = 2'b00,
        PE_WEIGHT_INPUT = 2'b01,
        PE_MULTIPLY     = 2'b10
    } pe_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_LOAD    = 2'b01,
        ST_COMPUTE = 2'b10,
        ST_DRAIN   = 2'b11
    } feeder_state_e;

    // LOAD feeds weights; COMPUTE and DRAIN keep PEs multiplying until flushed
    function automatic pe_ctrl_e state_ctrl(input feeder_state_e st);
        pe_ctrl_e ctrl;
        case (st)
            ST_LOAD:    ctrl = PE_WEIGHT_INPUT;
            ST_COMPUTE: ctrl = PE_MULTIPLY;
            ST_DRAIN:   ctrl = PE_MULTIPLY;
            default:    ctrl = PE_IDLE;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/systolic_act_feeder_skew_delay_line.sv
// Fixed-depth word delay line used to skew one array row; output is the last stage register.
module skew_delay_line #(
    parameter int WORD_WIDTH = 8,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_clear,
    input  logic [WORD_WIDTH-1:0] i_data,
    output logic [WORD_WIDTH-1:0] o_data
);

    logic [WORD_WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage[0] <= '0;
        end else if (i_clear) begin
            r_stage[0] <= '0;
        end else begin
            r_stage[0] <= i_data;
        end
    end

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_stage[gi] <= '0;
                end else if (i_clear) begin
                    r_stage[gi] <= '0;
                end else begin
                    r_stage[gi] <= r_stage[gi-1];
                end
            end
        end
    endgenerate

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/systolic_act_feeder.sv
// Activation feeder for a weight-stationary systolic array: sequences weight load,
// skews accepted activation vectors across rows, then drains the array.
module systolic_act_feeder
    import systolic_act_feeder_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int ARRAY_SIZE = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic                             act_valid,
    input  logic                             act_last,
    input  logic [ARRAY_SIZE*WORD_WIDTH-1:0] act_in,
    output logic                             act_ready,
    output logic [ARRAY_SIZE*WORD_WIDTH-1:0] a_out,
    output logic [2*ARRAY_SIZE-1:0]          control_out,
    output logic                             busy,
    output logic                             done
);

    localparam int              CNT_W      = $clog2(2*ARRAY_SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(ARRAY_SIZE-1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2*ARRAY_SIZE-2);

    feeder_state_e    r_state;
    feeder_state_e    w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    pe_ctrl_e         r_ctrl;
    logic             r_act_ready;
    logic             r_busy;
    logic             r_done;
    logic             w_handshake;
    logic             w_clear;

    assign w_handshake = act_valid & r_act_ready;
    assign w_clear     = (r_state == ST_IDLE);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_LOAD;
                    w_cnt_next   = '0;
                end
            end
            ST_LOAD: begin
                if (r_cnt == LOAD_LAST) begin
                    w_state_next = ST_COMPUTE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            ST_COMPUTE: begin
                if (w_handshake && act_last) begin
                    w_state_next = ST_DRAIN;
                    w_cnt_next   = '0;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state;
    // done is high during the final DRAIN cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ctrl      <= PE_IDLE;
            r_act_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_ctrl      <= state_ctrl(w_state_next);
            r_act_ready <= (w_state_next == ST_COMPUTE);
            r_busy      <= (w_state_next != ST_IDLE);
            r_done      <= (w_state_next == ST_DRAIN) && (w_cnt_next == DRAIN_LAST);
        end
    end

    assign act_ready = r_act_ready;
    assign busy      = r_busy;
    assign done      = r_done;

    generate
        for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_row
            logic [WORD_WIDTH-1:0] w_row_in;

            // Cycles without a handshake inject a zero bubble
            assign w_row_in = w_handshake ? act_in[gi*WORD_WIDTH +: WORD_WIDTH] : '0;
            assign control_out[2*gi +: 2] = r_ctrl;

            skew_delay_line #(
                .WORD_WIDTH (WORD_WIDTH),
                .DEPTH      (gi + 1)
            ) u_delay (
                .clk     (clk),
                .reset_n (reset_n),
                .i_clear (w_clear),
                .i_data  (w_row_in),
                .o_data  (a_out[gi*WORD_WIDTH +: WORD_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_systolic_act_feeder.sv
// Self-checking bench for systolic_act_feeder: directed table, hand sequences and
// randomized traffic against a cycle-history reference model.
module tb_systolic_act_feeder;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AW = N*W;

    localparam int P_IDLE    = 0;
    localparam int P_LOAD    = 1;
    localparam int P_COMPUTE = 2;
    localparam int P_DRAIN   = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          act_valid;
    logic          act_last;
    logic [AW-1:0] act_in;
    logic          act_ready;
    logic [AW-1:0] a_out;
    logic [2*N-1:0] control_out;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    systolic_act_feeder #(.WORD_WIDTH(W), .ARRAY_SIZE(N)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .act_valid   (act_valid),
        .act_last    (act_last),
        .act_in      (act_in),
        .act_ready   (act_ready),
        .a_out       (a_out),
        .control_out (control_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Reference model: session phase, remaining cycles in phase, and history of row-entry vectors
    int            m_phase;
    int            m_left;
    logic [AW-1:0] m_hist[$];

    task automatic model_reset();
        m_phase = P_IDLE;
        m_left  = 0;
        m_hist.delete();
        for (int i = 0; i < N; i++) m_hist.push_back('0);
    endtask

    task automatic model_edge(input logic s, input logic v, input logic l, input logic [AW-1:0] d);
        logic acc;
        acc = (m_phase == P_COMPUTE) && v;
        m_hist.push_front(acc ? d : '0);
        void'(m_hist.pop_back());
        case (m_phase)
            P_IDLE: if (s) begin m_phase = P_LOAD; m_left = N; end
            P_LOAD: begin
                m_left--;
                if (m_left == 0) m_phase = P_COMPUTE;
            end
            P_COMPUTE: if (acc && l) begin m_phase = P_DRAIN; m_left = 2*N-1; end
            default: begin
                m_left--;
                if (m_left == 0) m_phase = P_IDLE;
            end
        endcase
    endtask

    function automatic logic [AW-1:0] model_aout();
        logic [AW-1:0] r;
        logic [AW-1:0] h;
        r = '0;
        for (int i = 0; i < N; i++) begin
            h = m_hist[i];
            r[i*W +: W] = h[i*W +: W];
        end
        return r;
    endfunction

    function automatic logic [2*N-1:0] model_ctrl();
        logic [2*N-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            if (m_phase == P_LOAD) c[2*i +: 2] = 2'b01;
            else if (m_phase != P_IDLE) c[2*i +: 2] = 2'b10;
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".a_out"},   a_out, model_aout());
        check({tag, ".control"}, AW'(control_out), AW'(model_ctrl()));
        check({tag, ".ready"},   AW'(act_ready), AW'(m_phase == P_COMPUTE));
        check({tag, ".busy"},    AW'(busy), AW'(m_phase != P_IDLE));
        check({tag, ".done"},    AW'(done), AW'(m_phase == P_DRAIN && m_left == 1));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check just after it
    task automatic step(input string tag, input logic s, input logic v, input logic l, input logic [AW-1:0] d);
        start = s; act_valid = v; act_last = l; act_in = d;
        @(posedge clk);
        model_edge(s, v, l, d);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic          s;
        logic          v;
        logic          l;
        logic [AW-1:0] d;
        logic [2*N-1:0] ctrl;
        logic          rdy;
        logic          bsy;
        logic          dn;
        logic [AW-1:0] aout;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input logic s, input logic v, input logic l, input logic [AW-1:0] d,
                                input logic [2*N-1:0] ctrl, input logic rdy, input logic bsy,
                                input logic dn, input logic [AW-1:0] aout);
        vec_t t;
        t.s = s; t.v = v; t.l = l; t.d = d;
        t.ctrl = ctrl; t.rdy = rdy; t.bsy = bsy; t.dn = dn; t.aout = aout;
        return t;
    endfunction

    initial begin
        logic [AW-1:0] va;
        logic [AW-1:0] vb;
        logic          s;
        logic          v;
        logic          l;

        // start, LOAD for 4 cycles (act_valid ignored), COMPUTE, two back-to-back vectors, DRAIN 7, IDLE
        tbl[0]  = mk(1, 0, 0, 32'h0,        8'h55, 0, 1, 0, 32'h0);
        tbl[1]  = mk(0, 1, 0, 32'hDEADBEEF, 8'h55, 0, 1, 0, 32'h0);
        tbl[2]  = mk(0, 0, 0, 32'h0,        8'h55, 0, 1, 0, 32'h0);
        tbl[3]  = mk(0, 0, 0, 32'h0,        8'h55, 0, 1, 0, 32'h0);
        tbl[4]  = mk(1, 1, 0, 32'h99999999, 8'hAA, 1, 1, 0, 32'h0);
        tbl[5]  = mk(0, 1, 0, 32'h04030201, 8'hAA, 1, 1, 0, 32'h00000001);
        tbl[6]  = mk(1, 1, 1, 32'h08070605, 8'hAA, 0, 1, 0, 32'h00000205);
        tbl[7]  = mk(0, 0, 0, 32'h0,        8'hAA, 0, 1, 0, 32'h00030600);
        tbl[8]  = mk(0, 1, 0, 32'h11111111, 8'hAA, 0, 1, 0, 32'h04070000);
        tbl[9]  = mk(0, 0, 0, 32'h0,        8'hAA, 0, 1, 0, 32'h08000000);
        tbl[10] = mk(0, 0, 0, 32'h0,        8'hAA, 0, 1, 0, 32'h0);
        tbl[11] = mk(0, 0, 0, 32'h0,        8'hAA, 0, 1, 0, 32'h0);
        tbl[12] = mk(0, 0, 0, 32'h0,        8'hAA, 0, 1, 1, 32'h0);
        tbl[13] = mk(0, 0, 0, 32'h0,        8'h00, 0, 0, 0, 32'h0);

        reset_n = 1'b0; start = 1'b0; act_valid = 1'b0; act_last = 1'b0; act_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.a_out",   a_out, '0);
        check("reset.control", AW'(control_out), '0);
        check("reset.ready",   AW'(act_ready), '0);
        check("reset.busy",    AW'(busy), '0);
        check("reset.done",    AW'(done), '0);
        reset_n = 1'b1;
        step("idle", 0, 1, 1, 32'hCAFEF00D);

        for (int i = 0; i < 14; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].s, tbl[i].v, tbl[i].l, tbl[i].d);
            check($sformatf("tbl%0d.a_out", i),   a_out, tbl[i].aout);
            check($sformatf("tbl%0d.control", i), AW'(control_out), AW'(tbl[i].ctrl));
            check($sformatf("tbl%0d.ready", i),   AW'(act_ready), AW'(tbl[i].rdy));
            check($sformatf("tbl%0d.busy", i),    AW'(busy), AW'(tbl[i].bsy));
            check($sformatf("tbl%0d.done", i),    AW'(done), AW'(tbl[i].dn));
            $display("tbl%0d: in s=%b v=%b l=%b d=%h -> a_out=%h ctrl=%h rdy=%b busy=%b done=%b",
                     i, tbl[i].s, tbl[i].v, tbl[i].l, tbl[i].d, a_out, control_out, act_ready, busy, done);
        end

        // Two bubbles between vectors keep relative skew and control
        va = 32'hA4A3A2A1;
        vb = 32'hB4B3B2B1;
        step("bub.start", 1, 0, 0, '0);
        for (int i = 0; i < 4; i++) step("bub.load", 0, 0, 0, '0);
        step("bub.a", 0, 1, 0, va);
        step("bub.gap1", 0, 0, 0, 32'h12345678);
        check("bub.gap1.control", AW'(control_out), AW'(8'hAA));
        step("bub.gap2", 0, 0, 0, '0);
        step("bub.b", 0, 1, 1, vb);
        check("bub.skew", a_out, {va[31:24], 8'h00, 8'h00, vb[7:0]});
        $display("bubble: a_out=%h after last vector", a_out);
        for (int i = 0; i < 8; i++) step("bub.drain", 0, 0, 0, '0);

        // Reset asserted mid-COMPUTE aborts at once, then a fresh session
        step("rst.start", 1, 0, 0, '0);
        for (int i = 0; i < 4; i++) step("rst.load", 0, 0, 0, '0);
        step("rst.vec", 0, 1, 0, 32'h55667788);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst.a_out",   a_out, '0);
        check("rst.control", AW'(control_out), '0);
        check("rst.ready",   AW'(act_ready), '0);
        check("rst.busy",    AW'(busy), '0);
        check("rst.done",    AW'(done), '0);
        $display("midreset: a_out=%h ctrl=%h busy=%b", a_out, control_out, busy);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) step("rst.idle", 0, 0, 0, '0);
        step("rst.restart", 1, 0, 0, '0);
        for (int i = 0; i < 4; i++) step("rst.reload", 0, 0, 0, '0);
        check("rst.reload.control", AW'(control_out), AW'(8'hAA));

        // Randomized traffic with random start pulses in every phase
        for (int c = 0; c < 600; c++) begin
            s = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 2) != 0);
            l = v && ($urandom_range(0, 5) == 0);
            step("rand", s, v, l, AW'($urandom));
            if (v && act_ready === 1'b0 && m_phase == P_COMPUTE)
                $display("rand cycle %0d: v=%b l=%b a_out=%h", c, v, l, a_out);
        end
        $display("random phase: %0d cycles driven", 600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
